// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner and ROM word fetch feeding decode over valid/ready
// Optional feature macro: IFETCH_PERF_EN (adds perf_fetched / perf_redirects counters)
`ifndef MEM_ROM
`define MEM_ROM 1'b1
`endif

module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_type,
  output logic [31:0] mem_in_data,
  input  logic [31:0] mem_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_redirects
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic        capture;
  logic        take_redirect;
  logic        transfer;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // The ROM answers within the cycle, so the address is a pure function of the held pc.
  assign mem_address = {2'b00, pc_q[31:2]};
  assign mem_read    = (state_q != IDLE);
  assign mem_write   = 1'b0;
  assign mem_type    = `MEM_ROM;
  assign mem_in_data = 32'h0000_0000;

  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    valid_d       = valid_q;
    capture       = 1'b0;
    take_redirect = 1'b0;
    transfer      = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (redirect) begin
          take_redirect = 1'b1;
        end else begin
          capture = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        // A redirect squashes the presented instruction even when decode is ready.
        if (redirect) begin
          take_redirect = 1'b1;
        end else if (valid_q && instr_ready) begin
          capture  = 1'b1;
          transfer = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take_redirect) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      valid_d = 1'b0;
      state_d = FETCH;
    end

    if (capture) begin
      instr_d    = mem_data;
      instr_pc_d = pc_q;
      pc_d       = pc_q + 32'd4;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC_ALIGNED;
      instr_q    <= 32'h0000_0000;
      instr_pc_q <= 32'h0000_0000;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_redirects_q, perf_redirects_d;

  always_comb begin
    perf_fetched_d   = perf_fetched_q;
    perf_redirects_d = perf_redirects_q;
    if (transfer) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (take_redirect) begin
      perf_redirects_d = perf_redirects_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched_q   <= 32'h0000_0000;
      perf_redirects_q <= 32'h0000_0000;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_redirects_q <= perf_redirects_d;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_redirects = perf_redirects_q;
`else
  logic unused_transfer;
  assign unused_transfer = transfer;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - vector table plus transfer scoreboard for instruction_fetch
// Build with IFETCH_PERF_EN defined to also exercise the performance counters.
`ifndef MEM_ROM
`define MEM_ROM 1'b1
`endif

module tb_instruction_fetch;

  logic        clock;
  logic        reset;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic        mem_type;
  logic [31:0] mem_in_data;
  logic [31:0] mem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_redirects;
`endif

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clock         (clock),
    .reset         (reset),
    .mem_address   (mem_address),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_type      (mem_type),
    .mem_in_data   (mem_in_data),
    .mem_data      (mem_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_redirects(perf_redirects)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // ROM model: data appears on the negedge of the cycle in which mem_read is high.
  logic [31:0] rom [64];
  initial begin
    rom[0] = 32'h00300093; rom[1] = 32'h00000113; rom[2] = 32'h00110133;
    rom[3] = 32'hfff08093; rom[4] = 32'hfe009ce3; rom[5] = 32'h00010133;
    for (int i = 6; i < 64; i++) rom[i] = 32'hA5A5_0000 | i;
    mem_data = 32'h0;
  end
  always @(negedge clock) mem_data = mem_read ? rom[mem_address[5:0]] : 32'h0;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } xfer_t;
  xfer_t sb_q[$];
  bit    sb_on = 1'b0;

  // Transfer monitor: a transfer completes on the coming posedge.
  always @(negedge clock) begin
    if (sb_on && !reset && instr_valid && instr_ready && !redirect) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_transfer_pc", instr_pc, 32'hDEAD_BEEF);
      end else begin
        xfer_t e;
        e = sb_q.pop_front();
        chk("sb_instr", instr, e.ins);
        chk("sb_instr_pc", instr_pc, e.pc);
      end
    end
  end

  typedef struct {
    logic        rst, rdy, rd;
    logic [31:0] rpc;
    logic        ev, er;
    logic [31:0] ei, ep, ea;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic rdy, logic rd, logic [31:0] rpc,
                              logic ev, logic er, logic [31:0] ei, logic [31:0] ep,
                              logic [31:0] ea);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rd = rd; v.rpc = rpc;
    v.ev = ev; v.er = er; v.ei = ei; v.ep = ep; v.ea = ea;
    return v;
  endfunction

  task automatic step(input logic rst, input logic rdy, input logic rd, input logic [31:0] rpc);
    reset = rst; instr_ready = rdy; redirect = rd; redirect_pc = rpc;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r0, r1, r2, r3, r4, r5, r63;
    logic        prev_ev;
    logic [31:0] prev_ei, prev_ep;
    xfer_t       x;
    int          cyc;

    reset = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    r0 = 32'h00300093; r1 = 32'h00000113; r2 = 32'h00110133; r3 = 32'hfff08093;
    r4 = 32'hfe009ce3; r5 = 32'h00010133; r63 = 32'hA5A5_003F;

    tbl.push_back(mk(1,0,0,0,            0,0,0 ,0,0));
    tbl.push_back(mk(1,0,0,0,            0,0,0 ,0,0));
    tbl.push_back(mk(0,1,0,0,            0,1,0 ,0,0));
    tbl.push_back(mk(0,1,0,0,            1,1,r0,32'h0,1));
    tbl.push_back(mk(0,1,0,0,            1,1,r1,32'h4,2));
    tbl.push_back(mk(0,1,0,0,            1,1,r2,32'h8,3));
    tbl.push_back(mk(0,1,0,0,            1,1,r3,32'hC,4));
    tbl.push_back(mk(1,1,0,0,            0,0,0 ,0,0));
    tbl.push_back(mk(0,1,0,0,            0,1,0 ,0,0));
    tbl.push_back(mk(0,1,0,0,            1,1,r0,32'h0,1));
    tbl.push_back(mk(0,0,0,0,            1,1,r0,32'h0,1));
    tbl.push_back(mk(0,0,0,0,            1,1,r0,32'h0,1));
    tbl.push_back(mk(0,0,0,0,            1,1,r0,32'h0,1));
    tbl.push_back(mk(0,1,0,0,            1,1,r1,32'h4,2));
    tbl.push_back(mk(0,1,1,32'h10,       0,1,r1,32'h4,4));
    tbl.push_back(mk(0,1,0,0,            1,1,r4,32'h10,5));
    tbl.push_back(mk(0,1,0,0,            1,1,r5,32'h14,6));
    tbl.push_back(mk(0,1,1,32'h0E,       0,1,r5,32'h14,3));
    tbl.push_back(mk(0,1,0,0,            1,1,r3,32'hC,4));
    tbl.push_back(mk(0,0,1,32'h4,        0,1,r3,32'hC,1));
    tbl.push_back(mk(0,0,0,0,            1,1,r1,32'h4,2));
    tbl.push_back(mk(1,1,0,0,            0,0,0 ,0,0));
    tbl.push_back(mk(0,1,1,32'h20,       0,1,0 ,0,0));
    tbl.push_back(mk(0,1,1,32'h8,        0,1,0 ,0,2));
    tbl.push_back(mk(0,1,0,0,            1,1,r2,32'h8,3));
    tbl.push_back(mk(0,1,1,32'hFFFFFFFF, 0,1,r2,32'h8,32'h3FFF_FFFF));
    tbl.push_back(mk(0,1,0,0,            1,1,r63,32'hFFFF_FFFC,0));
    tbl.push_back(mk(0,1,0,0,            1,1,r0,32'h0,1));

    sb_on   = 1'b1;
    prev_ev = 1'b0; prev_ei = 32'h0; prev_ep = 32'h0;
    for (int i = 0; i < tbl.size(); i++) begin
      if (!tbl[i].rst && tbl[i].rdy && !tbl[i].rd && prev_ev) begin
        x.ins = prev_ei; x.pc = prev_ep;
        sb_q.push_back(x);
      end
      step(tbl[i].rst, tbl[i].rdy, tbl[i].rd, tbl[i].rpc);
      chk($sformatf("v%0d_valid", i),    {31'b0, instr_valid}, {31'b0, tbl[i].ev});
      chk($sformatf("v%0d_mem_read", i), {31'b0, mem_read},    {31'b0, tbl[i].er});
      chk($sformatf("v%0d_instr", i),    instr,                tbl[i].ei);
      chk($sformatf("v%0d_instr_pc", i), instr_pc,             tbl[i].ep);
      chk($sformatf("v%0d_mem_addr", i), mem_address,          tbl[i].ea);
      if (tbl[i].rst) begin
        chk($sformatf("v%0d_mem_write", i),   {31'b0, mem_write}, 32'h0);
        chk($sformatf("v%0d_mem_type", i),    {31'b0, mem_type},  {31'b0, `MEM_ROM});
        chk($sformatf("v%0d_mem_in_data", i), mem_in_data,        32'h0);
      end
      prev_ev = tbl[i].ev; prev_ei = tbl[i].ei; prev_ep = tbl[i].ep;
    end
    chk("table_sb_drained", sb_q.size(), 32'h0);

    // Sequential stream under random backpressure.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      x.ins = rom[k]; x.pc = 4 * k;
      sb_q.push_back(x);
    end
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 300) begin
      step(0, 1'($urandom_range(0, 1)), 0, 0);
      cyc++;
    end
    instr_ready = 1'b0;
    chk("random_stream_sb_drained", sb_q.size(), 32'h0);
    sb_q.delete();
    sb_on = 1'b0;

`ifdef IFETCH_PERF_EN
    step(1, 0, 0, 0);
    chk("perf_fetched_reset",   perf_fetched,   32'd0);
    chk("perf_redirects_reset", perf_redirects, 32'd0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("perf_fetched_one",     perf_fetched,   32'd1);
    step(0, 1, 1, 32'h10);
    chk("perf_redirects_one",   perf_redirects, 32'd1);
    chk("perf_fetched_squash",  perf_fetched,   32'd1);
    step(0, 1, 0, 0);
    chk("perf_fetched_capture", perf_fetched,   32'd1);
    step(0, 1, 0, 0);
    chk("perf_fetched_two",     perf_fetched,   32'd2);
    chk("perf_redirects_hold",  perf_redirects, 32'd1);
    step(1, 1, 1, 32'h20);
    chk("perf_fetched_clear",   perf_fetched,   32'd0);
    chk("perf_redirects_clear", perf_redirects, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
